i4002: RTL and testbench

MCS-4 RAM/output-port responder: the bus-side counterpart of the i4004 CPU. It snoops the 8-phase instruction cycle on the CPU's data bus and `cm_ram` lines, latches SRC addresses, and executes RAM/I/O group commands: memory read/write, status read/write, and output-port write. Instantiated up to 4×4 times beside the CPU (chip ID × bank); its `dbus_out` is OR-combined with the other responders before reaching the CPU's `dbus_in`.

---
 rtl/mcs4_pkg.sv | 47 ++++
 rtl/i4002_if.sv | 31 +++
 rtl/mcs4_phase_tracker.sv | 50 +++++
 rtl/i4002.sv | 140 ++++++++++++++
 tb/tb_i4002.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, bus nibble and the I/O-RAM
// opcode set carried on the data bus in M2.
package mcs4;

  typedef logic [3:0] char_t;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef enum logic [3:0] {
    OpWrm = 4'h0,
    OpWmp = 4'h1,
    OpWrr = 4'h2,
    OpWpm = 4'h3,
    OpWr0 = 4'h4,
    OpWr1 = 4'h5,
    OpWr2 = 4'h6,
    OpWr3 = 4'h7,
    OpSbm = 4'h8,
    OpRdm = 4'h9,
    OpRdr = 4'hA,
    OpAdm = 4'hB,
    OpRd0 = 4'hC,
    OpRd1 = 4'hD,
    OpRd2 = 4'hE,
    OpRd3 = 4'hF
  } ioram_opa_t;

  localparam int unsigned Ram_regs         = 4;
  localparam int unsigned Ram_chars        = 16;
  localparam int unsigned Ram_status_chars = 4;

  // Commands for which a RAM chip drives the bus in X2.
  function automatic logic is_ram_read(ioram_opa_t op);
    case (op)
      OpSbm, OpRdm, OpAdm, OpRd0, OpRd1, OpRd2, OpRd3: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_status_rd(ioram_opa_t op);
    case (op)
      OpRd0, OpRd1, OpRd2, OpRd3: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i4002_if.sv
// CPU-side bus bundle seen by an i4002 responder: sync, bank command lines,
// data bus in both directions and the chip's output port.
interface i4002_if;
  import mcs4::*;

  logic  sync;
  char_t cm_ram;
  char_t dbus_in;
  char_t dbus_out;
  logic  dbus_oe;
  char_t port_out;

  modport master (
    output sync,
    output cm_ram,
    output dbus_in,
    input  dbus_out,
    input  dbus_oe,
    input  port_out
  );

  modport slave (
    input  sync,
    input  cm_ram,
    input  dbus_in,
    output dbus_out,
    output dbus_oe,
    output port_out
  );

endinterface

// File: rtl/mcs4_phase_tracker.sv
// Follows the CPU's 8-phase instruction cycle from its sync pulse; any sync
// (on or off schedule) realigns the count so the next cycle is A1.
module mcs4_phase_tracker
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output instr_cyc_t phase,
  output logic       valid
);

  instr_cyc_t phase_q, phase_d;
  logic       valid_q, valid_d;

  always_comb begin
    phase_d = phase_q;
    valid_d = valid_q;
    if (sync) begin
      phase_d = A1;
      valid_d = 1'b1;
    end else if (valid_q) begin
      case (phase_q)
        A1:      phase_d = A2;
        A2:      phase_d = A3;
        A3:      phase_d = M1;
        M1:      phase_d = M2;
        M2:      phase_d = X1;
        X1:      phase_d = X2;
        X2:      phase_d = X3;
        X3:      phase_d = A1;
        default: phase_d = A1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= A1;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign phase = phase_q;
  assign valid = valid_q;

endmodule

// File: rtl/i4002.sv
// MCS-4 RAM / output-port responder: snoops SRC and I/O-RAM commands on the
// CPU bus and serves main memory, status characters and the output port.
module i4002 #(
  parameter int unsigned CHIP_ID = 0,
  parameter int unsigned BANK    = 0
) (
  input  logic     clk,
  input  logic     rst,
  i4002_if.slave   bus
);
  import mcs4::*;

  localparam logic [1:0] ChipId  = CHIP_ID[1:0];
  localparam logic [1:0] BankSel = BANK[1:0];

  instr_cyc_t phase;
  logic       valid;

  mcs4_phase_tracker u_phase (
    .clk   (clk),
    .rst   (rst),
    .sync  (bus.sync),
    .phase (phase),
    .valid (valid)
  );

  logic       selected_q, selected_d;
  logic [1:0] reg_sel_q, reg_sel_d;
  char_t      char_sel_q, char_sel_d;
  logic       src_pend_q, src_pend_d;
  ioram_opa_t cmd_q, cmd_d;
  logic       cmd_vld_q, cmd_vld_d;
  char_t      rd_data_q, rd_data_d;
  logic       drive_q, drive_d;
  char_t      port_q, port_d;
  char_t      main_q   [Ram_regs][Ram_chars];
  char_t      main_d   [Ram_regs][Ram_chars];
  char_t      status_q [Ram_regs][Ram_status_chars];
  char_t      status_d [Ram_regs][Ram_status_chars];

  logic       bank_hit;
  logic       exec;
  logic [3:0] cmd_raw;
  char_t      rd_src;

  assign bank_hit = bus.cm_ram[BankSel];
  assign exec     = valid && cmd_vld_q && selected_q;
  assign cmd_raw  = cmd_q;
  // Low opcode bits index the status character for WR0..3 / RD0..3.
  assign rd_src   = is_status_rd(cmd_q) ? status_q[reg_sel_q][cmd_raw[1:0]]
                                        : main_q[reg_sel_q][char_sel_q];

  always_comb begin
    selected_d = selected_q;
    reg_sel_d  = reg_sel_q;
    char_sel_d = char_sel_q;
    src_pend_d = src_pend_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = cmd_vld_q;
    rd_data_d  = rd_data_q;
    drive_d    = 1'b0;
    port_d     = port_q;
    main_d     = main_q;
    status_d   = status_q;

    if (valid) begin
      case (phase)
        M2: begin
          if (bank_hit) begin
            cmd_d     = ioram_opa_t'(bus.dbus_in);
            cmd_vld_d = 1'b1;
          end
        end
        X1: begin
          if (exec && is_ram_read(cmd_q)) begin
            rd_data_d = rd_src;
            drive_d   = 1'b1;
          end
        end
        X2: begin
          if (bank_hit) begin
            selected_d = (bus.dbus_in[3:2] == ChipId);
            reg_sel_d  = bus.dbus_in[1:0];
            src_pend_d = 1'b1;
          end
          if (exec) begin
            case (cmd_q)
              OpWrm:                      main_d[reg_sel_q][char_sel_q] = bus.dbus_in;
              OpWmp:                      port_d = bus.dbus_in;
              OpWr0, OpWr1, OpWr2, OpWr3: status_d[reg_sel_q][cmd_raw[1:0]] = bus.dbus_in;
              default: ;
            endcase
          end
        end
        X3: begin
          cmd_vld_d = 1'b0;
          if (src_pend_q) begin
            char_sel_d = bus.dbus_in;
            src_pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selected_q <= 1'b0;
      reg_sel_q  <= '0;
      char_sel_q <= '0;
      src_pend_q <= 1'b0;
      cmd_q      <= OpWrm;
      cmd_vld_q  <= 1'b0;
      rd_data_q  <= '0;
      drive_q    <= 1'b0;
      port_q     <= '0;
      main_q     <= '{default: '0};
      status_q   <= '{default: '0};
    end else begin
      selected_q <= selected_d;
      reg_sel_q  <= reg_sel_d;
      char_sel_q <= char_sel_d;
      src_pend_q <= src_pend_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      rd_data_q  <= rd_data_d;
      drive_q    <= drive_d;
      port_q     <= port_d;
      main_q     <= main_d;
      status_q   <= status_d;
    end
  end

  // Drive only for the X2 cycle so the wire-OR with other responders stays clean.
  assign bus.dbus_out = drive_q ? rd_data_q : '0;
  assign bus.dbus_oe  = drive_q;
  assign bus.port_out = port_q;

endmodule

// File: tb/tb_i4002.sv
// Bench for i4002 (CHIP_ID=2, BANK=1): directed instruction table, reset and
// sync corner cases, then random instructions against a per-instruction model.
module tb_i4002;
  import mcs4::*;

  localparam int unsigned ChipId = 2;
  localparam int unsigned Bank   = 1;

  logic clk = 1'b0;
  logic rst;

  i4002_if bus ();

  i4002 #(.CHIP_ID(ChipId), .BANK(Bank)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] m2_cm;
    logic [3:0] opa;
    logic [3:0] x2_cm;
    logic [3:0] x2_d;
    logic [3:0] x3_d;
    logic       exp_oe;
    logic [3:0] exp_rd;
    logic [3:0] exp_port;
  } vec_t;

  vec_t tbl [30];

  // Reference model state, one update per whole instruction.
  logic [3:0] m_main [4][16];
  logic [3:0] m_st   [4][4];
  logic [3:0] m_port;
  logic       m_sel;
  logic [1:0] m_reg;
  logic [3:0] m_chr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample mid-cycle on the falling edge, then clock.
  task automatic step(input logic s, input logic [3:0] cm, input logic [3:0] d,
                      output logic oe, output logic [3:0] dout);
    bus.sync    = s;
    bus.cm_ram  = cm;
    bus.dbus_in = d;
    @(negedge clk);
    oe   = bus.dbus_oe;
    dout = bus.dbus_out;
    @(posedge clk);
    #1;
  endtask

  // Full A1..X3 instruction; cm_ram in A3 and M2 (A3 must be ignored), noise elsewhere.
  task automatic instr(input logic [3:0] m2_cm, input logic [3:0] opa, input logic [3:0] x2_cm,
                       input logic [3:0] x2_d, input logic [3:0] x3_d,
                       output int oe_cycles, output int bad, output logic [3:0] rd);
    logic       oe;
    logic [3:0] dout, cm, d;
    oe_cycles = 0;
    bad       = 0;
    rd        = 4'h0;
    for (int p = 0; p < 8; p++) begin
      cm = (p == 2 || p == 4) ? m2_cm : (p == 6) ? x2_cm : 4'h0;
      d  = (p == 4) ? opa : (p == 6) ? x2_d : (p == 7) ? x3_d : 4'($urandom);
      step((p == 7), cm, d, oe, dout);
      if (oe) begin
        oe_cycles++;
        if (p == 6) rd = dout;
        else        bad++;
      end else if (dout != 4'h0) begin
        bad++;
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.sync    = 1'b0;
    bus.cm_ram  = 4'h0;
    bus.dbus_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) m_main[r][c] = 4'h0;
      for (int c = 0; c < 4; c++)  m_st[r][c]   = 4'h0;
    end
    m_port = 4'h0;
    m_sel  = 1'b0;
    m_reg  = 2'd0;
    m_chr  = 4'h0;
  endtask

  task automatic sync_pulse();
    logic       oe;
    logic [3:0] dout;
    step(1'b1, 4'h0, 4'h0, oe, dout);
  endtask

  // Model: returns whether the chip should drive and with what.
  task automatic model(input logic [3:0] m2_cm, input logic [3:0] opa, input logic [3:0] x2_cm,
                       input logic [3:0] x2_d, input logic [3:0] x3_d,
                       output logic exp_oe, output logic [3:0] exp_rd);
    exp_oe = 1'b0;
    exp_rd = 4'h0;
    if (x2_cm[Bank]) begin
      m_sel = (x2_d[3:2] == 2'(ChipId));
      m_reg = x2_d[1:0];
      m_chr = x3_d;
    end else if (m2_cm[Bank] && m_sel) begin
      if (opa == 4'h0) m_main[m_reg][m_chr] = x2_d;
      else if (opa == 4'h1) m_port = x2_d;
      else if (opa >= 4'h4 && opa <= 4'h7) m_st[m_reg][opa - 4'h4] = x2_d;
      else if (opa == 4'h8 || opa == 4'h9 || opa == 4'hB) begin
        exp_oe = 1'b1;
        exp_rd = m_main[m_reg][m_chr];
      end else if (opa >= 4'hC) begin
        exp_oe = 1'b1;
        exp_rd = m_st[m_reg][opa - 4'hC];
      end
    end
  endtask

  initial begin
    int         oe_cycles, bad, acq_bad;
    logic [3:0] rd, cm, opa, x2d, x3d, x2cm, dout;
    logic       oe, e_oe;
    logic [3:0] e_rd;

    tbl[0]  = '{4'h0, 4'h0, 4'h2, 4'hB, 4'h7, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{4'h2, 4'h0, 4'h0, 4'h5, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 4'h5, 4'h0};
    tbl[3]  = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h7, 1'b0, 4'h0, 4'h0};
    tbl[4]  = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[5]  = '{4'h2, 4'h0, 4'h0, 4'hA, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{4'h0, 4'h0, 4'h2, 4'hB, 4'h7, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 4'h5, 4'h0};
    tbl[8]  = '{4'h0, 4'h0, 4'h2, 4'h9, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[9]  = '{4'h2, 4'h6, 4'h0, 4'hC, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[10] = '{4'h2, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1, 4'hC, 4'h0};
    tbl[11] = '{4'h2, 4'h1, 4'h0, 4'h9, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[12] = '{4'h0, 4'h0, 4'h4, 4'h8, 4'h3, 1'b0, 4'h0, 4'h9};
    tbl[13] = '{4'h4, 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[14] = '{4'h2, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1, 4'hC, 4'h9};
    tbl[15] = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h9};
    tbl[16] = '{4'h0, 4'h0, 4'h2, 4'hB, 4'hF, 1'b0, 4'h0, 4'h9};
    tbl[17] = '{4'h6, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[18] = '{4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h9};
    tbl[19] = '{4'hF, 4'hB, 4'h0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h9};
    tbl[20] = '{4'h2, 4'hA, 4'h0, 4'h7, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[21] = '{4'h2, 4'h2, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[22] = '{4'h2, 4'h3, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[23] = '{4'h2, 4'hC, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h9};
    tbl[24] = '{4'h0, 4'h0, 4'h2, 4'hB, 4'h7, 1'b0, 4'h0, 4'h9};
    tbl[25] = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 4'h5, 4'h9};
    tbl[26] = '{4'h2, 4'h6, 4'h0, 4'h4, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[27] = '{4'h2, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h9};
    tbl[28] = '{4'h0, 4'h0, 4'h2, 4'h9, 4'h0, 1'b0, 4'h0, 4'h9};
    tbl[29] = '{4'h2, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1, 4'hC, 4'h9};

    // Reset state and sync acquisition.
    do_reset();
    chk("reset_oe", int'(bus.dbus_oe), 0);
    chk("reset_dout", int'(bus.dbus_out), 0);
    chk("reset_port", int'(bus.port_out), 0);
    chk("reset_valid", int'(dut.u_phase.valid), 0);
    acq_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'hF, 4'($urandom), oe, dout);
      if (oe || dout != 4'h0) acq_bad++;
    end
    chk("presync_drive", acq_bad, 0);
    chk("presync_port", int'(bus.port_out), 0);
    sync_pulse();
    chk("sync_phase_a1", int'(dut.u_phase.phase), int'(A1));
    chk("sync_valid", int'(dut.u_phase.valid), 1);

    // Directed instruction table.
    for (int i = 0; i < 30; i++) begin
      instr(tbl[i].m2_cm, tbl[i].opa, tbl[i].x2_cm, tbl[i].x2_d, tbl[i].x3_d,
            oe_cycles, bad, rd);
      chk($sformatf("vec%0d_oe_cycles", i), oe_cycles, int'(tbl[i].exp_oe));
      if (tbl[i].exp_oe) chk($sformatf("vec%0d_rd", i), int'(rd), int'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_stray_drive", i), bad, 0);
      chk($sformatf("vec%0d_port", i), int'(bus.port_out), int'(tbl[i].exp_port));
    end

    // Reset during X1 of a WRM to chip 2, reg 3, char 7.
    do_reset();
    sync_pulse();
    instr(4'h0, 4'h0, 4'h2, 4'hB, 4'h7, oe_cycles, bad, rd);
    step(1'b0, 4'h0, 4'h0, oe, dout);
    step(1'b0, 4'h0, 4'h0, oe, dout);
    step(1'b0, 4'h2, 4'h0, oe, dout);
    step(1'b0, 4'h0, 4'h0, oe, dout);
    step(1'b0, 4'h2, 4'h0, oe, dout);
    bus.cm_ram  = 4'h0;
    bus.dbus_in = 4'h5;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_oe", int'(bus.dbus_oe), 0);
    chk("midrst_dout", int'(bus.dbus_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", int'(dut.u_phase.valid), 0);
    acq_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'hF, (i == 4) ? 4'h1 : 4'hF, oe, dout);
      if (oe || dout != 4'h0) acq_bad++;
    end
    chk("postrst_nosync_drive", acq_bad, 0);
    chk("postrst_nosync_port", int'(bus.port_out), 0);
    sync_pulse();
    instr(4'h0, 4'h0, 4'h2, 4'hB, 4'h7, oe_cycles, bad, rd);
    instr(4'h2, 4'h9, 4'h0, 4'h0, 4'h0, oe_cycles, bad, rd);
    chk("midrst_rdm_oe", oe_cycles, 1);
    chk("midrst_char_zero", int'(rd), 0);

    // Random instructions against the model.
    do_reset();
    sync_pulse();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cm   = 4'h0;
        opa  = 4'h0;
        x2cm = 4'($urandom);
        x2d  = 4'($urandom);
        if ($urandom_range(0, 1) == 1) x2d[3:2] = 2'(ChipId);
        x3d  = 4'($urandom);
      end else begin
        cm   = 4'($urandom);
        if ($urandom_range(0, 3) != 0) cm[Bank] = 1'b1;
        opa  = 4'($urandom);
        x2cm = 4'h0;
        x2d  = 4'($urandom);
        x3d  = 4'($urandom);
      end
      model(cm, opa, x2cm, x2d, x3d, e_oe, e_rd);
      instr(cm, opa, x2cm, x2d, x3d, oe_cycles, bad, rd);
      chk($sformatf("rnd%0d_oe_cycles", n), oe_cycles, int'(e_oe));
      if (e_oe) chk($sformatf("rnd%0d_rd", n), int'(rd), int'(e_rd));
      chk($sformatf("rnd%0d_stray_drive", n), bad, 0);
      chk($sformatf("rnd%0d_port", n), int'(bus.port_out), int'(m_port));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
